// File: rtl/pc_if.sv
// Bundle between the control/branch-resolution logic and the PC unit.
interface pc_if #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned RAS_DEPTH = 4
);
  localparam int unsigned CW = $clog2(RAS_DEPTH) + 1;

  logic             pc_write;
  logic             branch_taken;
  logic [WIDTH-1:0] branch_target;
  logic             jump;
  logic [WIDTH-1:0] jump_target;
  logic             jr;
  logic [WIDTH-1:0] jr_target;
  logic             link;
  logic             exc_req;
  logic             eret;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_next_seq;
  logic [WIDTH-1:0] epc;
  logic             addr_err;
  logic [WIDTH-1:0] ras_top;
  logic             ras_valid;
  logic [CW-1:0]    ras_count;

  modport master (
    output pc_write, branch_taken, branch_target, jump, jump_target,
           jr, jr_target, link, exc_req, eret,
    input  pc, pc_next_seq, epc, addr_err, ras_top, ras_valid, ras_count
  );

  modport slave (
    input  pc_write, branch_taken, branch_target, jump, jump_target,
           jr, jr_target, link, exc_req, eret,
    output pc, pc_next_seq, epc, addr_err, ras_top, ras_valid, ras_count
  );
endinterface

// File: rtl/pc_unit.sv
// Program counter with next-PC selection, EPC capture, misalignment trap
// and a circular return-address stack for jal/jr prediction.
module pc_unit #(
  parameter int unsigned      WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [WIDTH-1:0] EXC_VECTOR   = 32'h8000_0180,
  parameter int unsigned      INSTR_BYTES  = 4,
  parameter int unsigned      RAS_DEPTH    = 4
) (
  input logic  clk,
  input logic  rst,
  pc_if.slave  bus
);
  localparam int unsigned      PW         = $clog2(RAS_DEPTH);
  localparam int unsigned      CW         = $clog2(RAS_DEPTH) + 1;
  localparam logic [WIDTH-1:0] INC        = WIDTH'(INSTR_BYTES);
  localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(INSTR_BYTES - 1);
  localparam logic [CW-1:0]    FULL       = CW'(RAS_DEPTH);

  logic [WIDTH-1:0] pc_q, epc_q, seq, tgt;
  logic             addr_err_q, has_tgt, misaligned, accept, ras_ok;
  logic             do_push, do_pop;
  logic [PW-1:0]    wp, top_idx, wr_idx;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];

  assign seq = pc_q + INC;

  // Redirect target by priority jr > jump > branch.
  always_comb begin
    tgt     = bus.branch_target;
    has_tgt = 1'b0;
    if (bus.jr) begin
      tgt     = bus.jr_target;
      has_tgt = 1'b1;
    end else if (bus.jump) begin
      tgt     = bus.jump_target;
      has_tgt = 1'b1;
    end else if (bus.branch_taken) begin
      has_tgt = 1'b1;
    end
  end

  assign misaligned = has_tgt && ((tgt & ALIGN_MASK) != '0);
  // Redirect sources only act when not pre-empted by exception or eret.
  assign accept     = bus.pc_write && !bus.exc_req && !bus.eret;
  assign ras_ok     = accept && !misaligned;
  assign do_push    = ras_ok && bus.link && (bus.jr || bus.jump);
  assign do_pop     = ras_ok && bus.jr;

  // PC, EPC and the misalignment pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q       <= RESET_VECTOR;
      epc_q      <= '0;
      addr_err_q <= 1'b0;
    end else begin
      addr_err_q <= 1'b0;
      if (bus.exc_req) begin
        pc_q  <= EXC_VECTOR;
        epc_q <= pc_q;
      end else if (bus.pc_write) begin
        if (bus.eret) begin
          pc_q <= epc_q;
        end else if (misaligned) begin
          pc_q       <= EXC_VECTOR;
          epc_q      <= pc_q;
          addr_err_q <= 1'b1;
        end else if (has_tgt) begin
          pc_q <= tgt;
        end else begin
          pc_q <= seq;
        end
      end
    end
  end

  // jalr on a non-empty stack rewrites the top slot in place.
  assign top_idx = wp - PW'(1);
  assign wr_idx  = (do_pop && count != '0) ? top_idx : wp;

  // RAS pointer and occupancy; overflow wraps onto the oldest entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp    <= '0;
      count <= '0;
    end else if (do_pop && do_push) begin
      if (count == '0) begin
        wp    <= wp + PW'(1);
        count <= CW'(1);
      end
    end else if (do_push) begin
      wp <= wp + PW'(1);
      if (count != FULL) count <= count + CW'(1);
    end else if (do_pop && count != '0) begin
      wp    <= top_idx;
      count <= count - CW'(1);
    end
  end

  // RAS storage; contents are masked by count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (do_push) ras_mem[wr_idx] <= seq;
  end

  assign bus.pc          = pc_q;
  assign bus.pc_next_seq = seq;
  assign bus.epc         = epc_q;
  assign bus.addr_err    = addr_err_q;
  assign bus.ras_count   = count;
  assign bus.ras_valid   = (count != '0);
  assign bus.ras_top     = (count != '0) ? ras_mem[top_idx] : '0;
endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter unit for the MIPS core.
- Holds the PC and selects the next PC from these sources: sequential, branch, jump, register jump, exception vector and exception return.
- Captures the exception PC (EPC) and flags misaligned targets.
- Maintains a small circular return-address stack (RAS) for jal/jr return prediction.
- Sits at the head of the fetch stage and is driven by the control unit and the branch/jump resolution logic.

Parameters:
- WIDTH, 32: PC and address width in bits.
- RESET_VECTOR, 32'h0000_0000: PC value after reset.
- EXC_VECTOR, 32'h8000_0180: PC loaded on any exception.
- INSTR_BYTES, 4: sequential increment; also the alignment unit (power of 2).
- RAS_DEPTH, 4: return-address-stack entries (power of 2, ≥2).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset: asynchronous assert, active-low, synchronous deassert outside this block.
- pc_write  in  1  1 = PC may advance; 0 = stall.
- branch_taken  in  1  take branch_target.
- branch_target  in  WIDTH  branch destination.
- jump  in  1  take jump_target.
- jump_target  in  WIDTH  jump destination (already formed by the jump logic).
- jr  in  1  take jr_target (register jump).
- jr_target  in  WIDTH  register jump destination.
- link  in  1  with jump or jr: push pc+INSTR_BYTES onto the RAS.
- exc_req  in  1  external exception request.
- eret  in  1  return from exception.
- pc  out  WIDTH  current PC (registered).
- pc_next_seq  out  WIDTH  pc+INSTR_BYTES (combinational, modulo 2^WIDTH).
- epc  out  WIDTH  captured exception PC (registered).
- addr_err  out  1  one-cycle pulse when a misaligned target was trapped (registered).
- ras_top  out  WIDTH  predicted return address; 0 when the RAS is empty.
- ras_valid  out  1  RAS non-empty.
- ras_count  out  $clog2(RAS_DEPTH)+1  number of valid RAS entries.

Behaviour:
- Reset (rst=0, asynchronous) forces:
  - pc=RESET_VECTOR, epc=0, addr_err=0.
  - RAS write pointer=0, ras_count=0, ras_valid=0.
- All state updates occur on posedge clk. Next-PC priority, highest first:
  1. exc_req: pc<=EXC_VECTOR, epc<=pc. Taken even when pc_write=0. addr_err<=0.
  2. eret: pc<=epc.
  3. jr: pc<=jr_target.
  4. jump: pc<=jump_target.
  5. branch_taken: pc<=branch_target.
  6. Otherwise: pc<=pc+INSTR_BYTES, wrapping modulo 2^WIDTH.
- Sources 2–6 take effect only when pc_write=1. When pc_write=0 and exc_req=0, pc, epc and the RAS hold, and addr_err<=0.
- Misalignment:
  - A target from source 3, 4 or 5 is misaligned when target mod INSTR_BYTES ≠ 0.
  - If the selected target is misaligned and pc_write=1, the redirect is not taken. Instead: pc<=EXC_VECTOR, epc<=pc, addr_err<=1 for exactly one cycle, and no RAS push/pop.
  - exc_req coincident with a misaligned target: exc_req wins and addr_err stays 0.
- addr_err is 0 in every cycle not described above.
- RAS operations occur only when the owning jr/jump source is the selected, accepted, aligned source:
  - jump & link: push pc+INSTR_BYTES.
  - jr & !link: pop.
  - jr & link (jalr): pop, then push. The top entry is replaced by pc+INSTR_BYTES and ras_count is unchanged. On an empty stack this behaves as a plain push.
- Push when ras_count=RAS_DEPTH: the oldest entry is overwritten (circular) and ras_count stays RAS_DEPTH.
- Pop when empty: ignored. ras_count stays 0 and pc still takes jr_target.
- exc_req, eret, branch and sequential advance never modify the RAS.
- ras_top, ras_valid and ras_count reflect registered state. A push/pop is visible the cycle after its clock edge.

Test Plan:
- Reset and wrap: rst=0 mid-run → pc=0 immediately, epc=0, ras_count=0. Release, pc_write=1 for 3 cycles → pc=0,4,8,12. Preload pc=32'hFFFF_FFFC → next pc=0.
- Priority: branch_taken, jump and jr all asserted with targets 0x100/0x200/0x300 → pc=0x300. Add exc_req in the same cycle → pc=0x8000_0180, epc=old pc, RAS unchanged.
- Stall and exception: pc_write=0 for 4 cycles with branch_taken=1 → pc constant. Assert exc_req with pc_write=0 → pc=0x8000_0180. Then eret with pc_write=1 → pc=saved epc.
- Misaligned: pc=0x40, jump=1, jump_target=0x102 → pc=0x8000_0180, epc=0x40, addr_err high for exactly 1 cycle, ras_count unchanged even with link=1.
- RAS overflow/underflow (RAS_DEPTH=4): 5 jump&link from pc=0x10,0x20,0x30,0x40,0x50 → ras_count=4, ras_top=0x54. Then 5 jr → ras_top sequence 0x44,0x34,0x24,then invalid. The fifth pop leaves ras_count=0 and pc=jr_target.
- jalr: ras_count=2, top=0x24, jr&link at pc=0x80 → ras_top=0x84, ras_count=2.
